// File: rtl/bot_update_scheduler.sv
// Bot update scheduler.
// Collects one state word per bot per frame. A round-robin arbiter picks one requester at a
// time, latches its word, acks it and presents it downstream. A frame closes when every bot
// has been serviced or when the frame timer expires. On close, the block reports which bots
// were missed and whether the close was caused by the timer.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   req               per-bot "new word ready"
//   bot_data          per-bot {vx,vy,x,y}, 16-bit Q5.11 each, bot i in slot i, vx in MSBs
//   ack               one-cycle pulse to the bot whose word was consumed
//   sel_id            index of the bot whose word is on the outputs
//   vx/vy/x/y_out     latched word fields
//   out_valid         output word valid; held with the data until out_ready
//   out_ready         downstream accepts the word
//   frame_done        one-cycle pulse at frame close
//   frame_timeout     set when the last frame closed on the timer; held until the next close
//   missing           bots not serviced in the last closed frame; held until the next close
module bot_update_scheduler #(
  parameter int unsigned N_BOT   = 3,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BOT-1:0]      req,
  input  logic [64*N_BOT-1:0]   bot_data,
  output logic [N_BOT-1:0]      ack,
  output logic [1:0]            sel_id,
  output logic [15:0]           vx_out,
  output logic [15:0]           vy_out,
  output logic [15:0]           x_out,
  output logic [15:0]           y_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  frame_timeout,
  output logic [N_BOT-1:0]      missing
);

  localparam int unsigned        CntW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]    CntMax    = CntW'(TIMEOUT - 1);
  localparam logic [N_BOT-1:0]   AllServed = '1;

  typedef enum logic [1:0] {StIdle, StLatch, StOut, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [N_BOT-1:0]  r_served, w_served_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]        r_last, w_last_nxt;
  logic [1:0]        r_sel, w_sel_nxt;
  logic [N_BOT-1:0]  r_ack, w_ack_nxt;
  logic [15:0]       r_vx, w_vx_nxt;
  logic [15:0]       r_vy, w_vy_nxt;
  logic [15:0]       r_x, w_x_nxt;
  logic [15:0]       r_y, w_y_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [N_BOT-1:0]  r_missing, w_missing_nxt;

  logic [N_BOT-1:0]  w_eligible;
  logic              w_found;
  logic [1:0]        w_grant;
  int unsigned       w_dist;
  int unsigned       w_best;
  logic [63:0]       w_slot;
  logic [N_BOT-1:0]  w_sel_oh;
  logic              w_timed_out;

  // Round-robin: the eligible bot closest after last_grant (wrapping) wins.
  always_comb begin
    w_eligible = req & ~r_served;
    w_found    = 1'b0;
    w_grant    = '0;
    w_dist     = 0;
    w_best     = N_BOT;
    for (int unsigned i = 0; i < N_BOT; i++) begin
      w_dist = (i + N_BOT - 1 - 32'(r_last)) % N_BOT;
      if (w_eligible[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_grant = 2'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_slot   = 64'(bot_data >> (64 * 32'(r_sel)));
  assign w_sel_oh = N_BOT'(1) << r_sel;

  // The timer only matters once something has been served; a fully served frame closes
  // through the OUT path instead.
  assign w_timed_out = (r_served != '0) && (r_served != AllServed) && (r_cnt == CntMax);

  always_comb begin
    w_state_nxt   = r_state;
    w_served_nxt  = r_served;
    w_last_nxt    = r_last;
    w_sel_nxt     = r_sel;
    w_ack_nxt     = '0;
    w_vx_nxt      = r_vx;
    w_vy_nxt      = r_vy;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_timeout_nxt = r_timeout;
    w_missing_nxt = r_missing;
    w_cnt_nxt     = r_cnt;
    if ((r_served != '0) && (r_cnt != CntMax)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        // Timer expiry is only acted on here, so a word already latched is never dropped.
        if (w_timed_out) begin
          w_state_nxt   = StDone;
          w_timeout_nxt = 1'b1;
          w_missing_nxt = ~r_served;
        end else if (w_found) begin
          w_state_nxt = StLatch;
          w_sel_nxt   = w_grant;
        end
      end
      StLatch: begin
        w_vx_nxt     = w_slot[63:48];
        w_vy_nxt     = w_slot[47:32];
        w_x_nxt      = w_slot[31:16];
        w_y_nxt      = w_slot[15:0];
        w_ack_nxt    = w_sel_oh;
        w_served_nxt = r_served | w_sel_oh;
        w_last_nxt   = r_sel;
        w_state_nxt  = StOut;
      end
      StOut: begin
        if (out_ready) begin
          if (r_served == AllServed) begin
            w_state_nxt   = StDone;
            w_timeout_nxt = 1'b0;
            w_missing_nxt = ~r_served;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      StDone: begin
        w_served_nxt = '0;
        w_cnt_nxt    = '0;
        w_state_nxt  = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_served  <= '0;
      r_cnt     <= '0;
      r_last    <= 2'(N_BOT - 1);
      r_sel     <= '0;
      r_ack     <= '0;
      r_vx      <= '0;
      r_vy      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_timeout <= 1'b0;
      r_missing <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_served  <= w_served_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_sel     <= w_sel_nxt;
      r_ack     <= w_ack_nxt;
      r_vx      <= w_vx_nxt;
      r_vy      <= w_vy_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_timeout <= w_timeout_nxt;
      r_missing <= w_missing_nxt;
    end
  end

  assign ack           = r_ack;
  assign sel_id        = r_sel;
  assign vx_out        = r_vx;
  assign vy_out        = r_vy;
  assign x_out         = r_x;
  assign y_out         = r_y;
  assign out_valid     = (r_state == StOut);
  assign frame_done    = (r_state == StDone);
  assign frame_timeout = r_timeout;
  assign missing       = r_missing;

endmodule

// File: tb/tb_bot_update_scheduler.sv
// Self-checking bench for bot_update_scheduler (N_BOT=3, TIMEOUT=16).
module tb_bot_update_scheduler;

  localparam int NB = 3;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   req = '0;
  logic [191:0] bot_data = '0;
  logic [2:0]   ack;
  logic [1:0]   sel_id;
  logic [15:0]  vx_out, vy_out, x_out, y_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         frame_done, frame_timeout;
  logic [2:0]   missing;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [63:0] d [NB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bot_update_scheduler #(.N_BOT(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .bot_data(bot_data), .ack(ack), .sel_id(sel_id),
    .vx_out(vx_out), .vy_out(vy_out), .x_out(x_out), .y_out(y_out), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done), .frame_timeout(frame_timeout),
    .missing(missing)
  );

  // Reference arbiter: first requester after 'last', wrapping; -1 if none.
  function automatic int rr_pick(input logic [2:0] elig, input int last);
    int c;
    logic [2:0] sh;
    for (int o = 1; o <= NB; o++) begin
      c = (last + o) % NB;
      sh = elig >> c;
      if (sh[0]) return c;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int b);
    return 3'(1) << b;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; req = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NB; i++) begin
      d[i] = {$urandom(), $urandom()};
      bot_data[i*64 +: 64] = d[i];
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack !== 3'b000) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; req = 3'b111; out_ready = 1'b1; rand_data();
    @(negedge clk);
    checks++; if (ack !== 3'b000 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got ack=%b valid=%b done=%b exp 000/0/0", ack, out_valid, frame_done);
    end
    checks++; if (frame_timeout !== 1'b0 || missing !== 3'b000 || sel_id !== 2'd0) begin
      failures++; $display("FAIL reset_status got to=%b miss=%b sel=%0d exp 0/000/0", frame_timeout, missing, sel_id);
    end
    checks++; if ({vx_out, vy_out, x_out, y_out} !== 64'h0) begin
      failures++; $display("FAIL reset_data got %h exp 0", {vx_out, vy_out, x_out, y_out});
    end
    rst = 1'b0;
    wait_ack(ok);
    checks++; if (!ok || ack !== 3'b001) begin
      failures++; $display("FAIL reset_first_grant got ack=%b ok=%0d exp 001", ack, ok);
    end
    apply_reset();
  endtask

  task automatic test_single();
    bit ok;
    int t_ack, quiet_bad;
    apply_reset(); rand_data();
    d[0] = 64'h0C00_F800_1000_0400; bot_data[63:0] = d[0];
    req = 3'b001; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 3'b000 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_cycle1 got ack=%b valid=%b exp 000/0", ack, out_valid);
    end
    @(negedge clk);
    t_ack = cyc;
    checks++; if (ack !== 3'b001 || out_valid !== 1'b1 || sel_id !== 2'd0) begin
      failures++; $display("FAIL single_cycle2 got ack=%b valid=%b sel=%0d exp 001/1/0", ack, out_valid, sel_id);
    end
    checks++; if ({vx_out, vy_out, x_out, y_out} !== 64'h0C00_F800_1000_0400) begin
      failures++; $display("FAIL single_word got %h exp 0c00f80010000400", {vx_out, vy_out, x_out, y_out});
    end
    out_ready = 1'b1; req = 3'b000;
    quiet_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || ack !== 3'b000) quiet_bad++;
    end
    checks++; if (quiet_bad != 0) begin
      failures++; $display("FAIL single_quiet got %0d bad cycles exp 0", quiet_bad);
    end
    wait_done(ok);
    checks++; if (!ok || (cyc - t_ack) != TO || missing !== 3'b110 || frame_timeout !== 1'b1) begin
      failures++; $display("FAIL single_timeout got dt=%0d miss=%b to=%b exp dt=%0d miss=110 to=1",
                           cyc - t_ack, missing, frame_timeout, TO);
    end
  endtask

  task automatic test_all_bots();
    int last, e, n, ndone, tdone;
    int ta [3];
    logic [2:0] served;
    for (int it = 0; it < 3; it++) begin
      apply_reset(); rand_data();
      last = NB - 1; served = '0; n = 0; ndone = 0; tdone = -1;
      ta[0] = 0; ta[1] = 0; ta[2] = 0;
      req = 3'b111; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ack !== 3'b000) begin
          e = rr_pick(3'b111 & ~served, last);
          checks++;
          if (e < 0) begin
            failures++; $display("FAIL all_extra_ack got ack=%b exp none", ack);
          end else if (ack !== onehot(e) || sel_id !== 2'(e) || out_valid !== 1'b1 ||
                       {vx_out, vy_out, x_out, y_out} !== d[e]) begin
            failures++; $display("FAIL all_grant got ack=%b sel=%0d data=%h exp ack=%b sel=%0d data=%h",
                                 ack, sel_id, {vx_out, vy_out, x_out, y_out}, onehot(e), e, d[e]);
          end
          if (e >= 0) begin served |= onehot(e); last = e; end
          if (n < 3) ta[n] = cyc;
          n++;
          if (n == 3) req = 3'b000;
        end
        if (frame_done === 1'b1) begin
          ndone++; tdone = cyc;
          checks++; if (missing !== 3'b000 || frame_timeout !== 1'b0) begin
            failures++; $display("FAIL all_status got miss=%b to=%b exp 000/0", missing, frame_timeout);
          end
        end
      end
      checks++; if (n != 3 || ndone != 1) begin
        failures++; $display("FAIL all_counts got acks=%0d dones=%0d exp 3/1", n, ndone);
      end
      checks++; if (ta[1] - ta[0] != 3 || ta[2] - ta[1] != 3 || tdone != ta[2] + 1) begin
        failures++; $display("FAIL all_timing got gaps=%0d,%0d done_dt=%0d exp 3,3,1",
                             ta[1] - ta[0], ta[2] - ta[1], tdone - ta[2]);
      end
    end
  endtask

  task automatic test_random_frames();
    int last, e, n, stall, cur, t_first, t_acc, t_done;
    logic [2:0] m, served;
    bit got;
    for (int it = 0; it < 10; it++) begin
      apply_reset(); rand_data();
      m = 3'($urandom_range(1, 7));
      last = NB - 1; served = '0; n = 0; stall = 0; cur = 0;
      t_first = 0; t_acc = 0; t_done = 0; got = 1'b0;
      req = m; out_ready = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (ack !== 3'b000) begin
          e = rr_pick(m & ~served, last);
          checks++;
          if (e < 0) begin
            failures++; $display("FAIL rand_extra_ack got ack=%b exp none", ack);
          end else if (ack !== onehot(e) || sel_id !== 2'(e) ||
                       {vx_out, vy_out, x_out, y_out} !== d[e]) begin
            failures++; $display("FAIL rand_grant got ack=%b sel=%0d data=%h exp ack=%b sel=%0d data=%h",
                                 ack, sel_id, {vx_out, vy_out, x_out, y_out}, onehot(e), e, d[e]);
          end
          if (e >= 0) begin served |= onehot(e); last = e; cur = e; end
          if (n == 0) t_first = cyc;
          n++;
          stall = $urandom_range(0, 2);
        end else if (out_valid === 1'b1) begin
          checks++; if (sel_id !== 2'(cur) || {vx_out, vy_out, x_out, y_out} !== d[cur]) begin
            failures++; $display("FAIL rand_hold got sel=%0d data=%h exp sel=%0d data=%h",
                                 sel_id, {vx_out, vy_out, x_out, y_out}, cur, d[cur]);
          end
        end
        if (frame_done === 1'b1) begin got = 1'b1; t_done = cyc; end
        if (out_valid === 1'b1) begin
          if (stall > 0) begin out_ready = 1'b0; stall--; end
          else out_ready = 1'b1;
        end else begin
          out_ready = 1'b0;
        end
        if (out_valid === 1'b1 && out_ready) t_acc = cyc + 1;
      end
      checks++; if (!got || n != $countones(m)) begin
        failures++; $display("FAIL rand_count mask=%b got done=%0d acks=%0d exp 1/%0d", m, got, n, $countones(m));
      end
      if (m == 3'b111) begin
        checks++; if (t_done != t_acc || frame_timeout !== 1'b0 || missing !== 3'b000) begin
          failures++; $display("FAIL rand_full got dt=%0d to=%b miss=%b exp 0/0/000", t_done - t_acc, frame_timeout, missing);
        end
      end else begin
        checks++; if (t_done - t_first != TO || frame_timeout !== 1'b1 || missing !== ~m) begin
          failures++; $display("FAIL rand_timeout mask=%b got dt=%0d to=%b miss=%b exp %0d/1/%b",
                               m, t_done - t_first, frame_timeout, missing, TO, ~m);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    apply_reset(); rand_data();
    req = 3'b001; out_ready = 1'b0;
    wait_ack(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_ack got none exp 001"); end
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sel_id !== 2'd0 || {vx_out, vy_out, x_out, y_out} !== d[0] ||
          ack !== ((i == 0) ? 3'b001 : 3'b000)) begin
        failures++; $display("FAIL bp_hold cyc%0d got valid=%b sel=%0d ack=%b data=%h exp 1/0/-/%h",
                             i, out_valid, sel_id, ack, {vx_out, vy_out, x_out, y_out}, d[0]);
      end
      if (i == 5) out_ready = 1'b1;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_accept got valid=%b exp 0", out_valid);
    end
    bad = 0;
    repeat (4) begin @(negedge clk); if (ack !== 3'b000) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_regrant got %0d acks exp 0", bad); end
    wait_done(ok);
  endtask

  task automatic test_mask();
    bit ok;
    int bad;
    apply_reset(); rand_data();
    req = 3'b001; out_ready = 1'b1;
    wait_ack(ok);
    checks++; if (!ok || ack !== 3'b001) begin failures++; $display("FAIL mask_first got ack=%b exp 001", ack); end
    bad = 0;
    repeat (4) begin @(negedge clk); if (ack !== 3'b000) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL mask_regrant got %0d acks exp 0", bad); end
    req = 3'b101;
    wait_ack(ok);
    checks++; if (!ok || ack !== 3'b100 || sel_id !== 2'd2 || {vx_out, vy_out, x_out, y_out} !== d[2]) begin
      failures++; $display("FAIL mask_second got ack=%b sel=%0d data=%h exp 100/2/%h",
                           ack, sel_id, {vx_out, vy_out, x_out, y_out}, d[2]);
    end
    req = 3'b000;
    wait_done(ok);
    checks++; if (!ok || missing !== 3'b010 || frame_timeout !== 1'b1) begin
      failures++; $display("FAIL mask_close got miss=%b to=%b exp 010/1", missing, frame_timeout);
    end
  endtask

  task automatic test_deferred_timeout();
    bit ok;
    int bad;
    apply_reset(); rand_data();
    req = 3'b001; out_ready = 1'b0;
    wait_ack(ok);
    req = 3'b000;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || frame_done !== 1'b0) bad++;
    end
    checks++; if (!ok || bad != 0 || {vx_out, vy_out, x_out, y_out} !== d[0]) begin
      failures++; $display("FAIL defer_hold got bad=%0d data=%h exp 0/%h", bad, {vx_out, vy_out, x_out, y_out}, d[0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
      failures++; $display("FAIL defer_accept got valid=%b done=%b exp 0/0", out_valid, frame_done);
    end
    @(negedge clk);
    checks++; if (frame_done !== 1'b1 || frame_timeout !== 1'b1 || missing !== 3'b110) begin
      failures++; $display("FAIL defer_close got done=%b to=%b miss=%b exp 1/1/110", frame_done, frame_timeout, missing);
    end
    repeat (3) @(negedge clk);
    checks++; if (frame_done !== 1'b0 || frame_timeout !== 1'b1 || missing !== 3'b110) begin
      failures++; $display("FAIL defer_sticky got done=%b to=%b miss=%b exp 0/1/110", frame_done, frame_timeout, missing);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset(); rand_data();
    req = 3'b011; out_ready = 1'b0;
    wait_ack(ok);
    checks++; if (!ok || ack !== 3'b001) begin failures++; $display("FAIL rmid_first got ack=%b exp 001", ack); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || ack !== 3'b000 || frame_done !== 1'b0 ||
                  {vx_out, vy_out, x_out, y_out} !== 64'h0) begin
      failures++; $display("FAIL rmid_async got valid=%b ack=%b done=%b data=%h exp 0/000/0/0",
                           out_valid, ack, frame_done, {vx_out, vy_out, x_out, y_out});
    end
    @(negedge clk);
    rst = 1'b0;
    wait_ack(ok);
    checks++; if (!ok || ack !== 3'b001 || {vx_out, vy_out, x_out, y_out} !== d[0]) begin
      failures++; $display("FAIL rmid_regrant got ack=%b data=%h exp 001/%h", ack, {vx_out, vy_out, x_out, y_out}, d[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_bots();
    test_random_frames();
    test_backpressure();
    test_mask();
    test_deferred_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bot_update_scheduler.md
BOT_UPDATE_SCHEDULER -- requirements
Module: bot_update_scheduler

Interface
REQ-001 Parameter: N_BOT, 3, number of bot update sources.
REQ-002 Parameter: TIMEOUT, 1000, frame timeout in clk cycles.
REQ-003 Port: clk  in  1  single system clock; all logic is on the rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  N_BOT  bit i high means bot i has a new state word ready.
REQ-006 Port: bot_data  in  64*N_BOT  slot i = {vx,vy,x,y} for bot i, each field 16-bit Q5.11 two's complement, vx in MSBs.
REQ-007 Port: ack  out  N_BOT  one-cycle pulse to bot i confirming its word was consumed.
REQ-008 Port: sel_id  out  2  index of the bot whose word is on the outputs.
REQ-009 Port: vx_out, vy_out, x_out, y_out  out  16 each  latched Q5.11 fields.
REQ-010 Port: out_valid  out  1  output word valid.
REQ-011 Port: out_ready  in  1  downstream accepts the word.
REQ-012 Port: frame_done  out  1  one-cycle pulse at frame close.
REQ-013 Port: frame_timeout  out  1  qualifies frame_done; high when the frame closed by timeout.
REQ-014 Port: missing  out  N_BOT  bots not serviced in the closed frame; valid with frame_done.

Function
REQ-015 The FSM shall have exactly four states: IDLE, LATCH, OUT and DONE.
REQ-016 IDLE: the block shall arbitrate among eligible requesters, where eligible = req & ~served.
  - Arbitration is round-robin, starting at last_grant+1 and wrapping from N_BOT-1 to 0.
  - If any requester is eligible, the block shall latch sel_id and go to LATCH.
REQ-017 LATCH: the block shall perform all of the following in the same cycle, then go to OUT.
  - Capture bot_data[sel_id] into the four output registers.
  - Pulse ack[sel_id] high for exactly one cycle.
  - Set served[sel_id] and update last_grant.
REQ-018 OUT: out_valid shall be 1.
  - Outputs shall be held stable until out_ready is 1.
  - On out_ready, the block shall go to DONE if served is all ones, else to IDLE.
REQ-019 DONE: frame_done shall be 1 for exactly one cycle.
  - missing = ~served captured before the clear.
  - served and the frame counter shall be cleared; next state is IDLE.
REQ-020 A bot whose served bit is set shall not be granted again until frame close, even if its req stays high.
REQ-021 Frame counter behaviour:
  - Starts at 0 on the first grant of a frame and increments every cycle while served is nonzero.
  - Saturates at TIMEOUT-1.
REQ-022 If the counter is at TIMEOUT-1 while in IDLE and served is not all ones, the block shall go to DONE with frame_timeout=1.
REQ-023 A timeout during LATCH or OUT shall be deferred until the return to IDLE; in-flight words shall never be dropped.
REQ-024 frame_timeout and missing shall hold their values until the next DONE.
REQ-025 Best-case latency:
  - req to ack: 2 cycles.
  - req to out_valid: 2 cycles.
  - Consecutive grants are at least 3 cycles apart (IDLE, LATCH, OUT).
REQ-026 The block shall not combinationally depend on bot_data except through the LATCH capture; out_valid shall never depend combinationally on out_ready.

Reset
REQ-027 On rst=1 the block shall asynchronously go to IDLE, and all of the following shall be 0:
  - served, frame counter.
  - ack, out_valid, frame_done, frame_timeout, missing.
  - sel_id, vx_out, vy_out, x_out, y_out.
REQ-028 On rst=1, last_grant shall be N_BOT-1, so that bot 0 has first priority.
REQ-029 Reset asserted mid-operation (LATCH or OUT) shall discard the word with no ack or frame_done pulse; the bot re-requests.

Verification
REQ-030 Single bot: req=3'b001, bot0 = {0x0C00,0xF800,0x1000,0x0400} -> ack[0] pulses on cycle 2; out_valid with vx_out=0x0C00 (1.5), vy_out=0xF800 (-1.0), sel_id=0; no frame_done.
REQ-031 All bots: req=3'b111 held, out_ready=1 -> grants in order 0,1,2; each ack pulses once; frame_done on cycle after third accept; missing=0, frame_timeout=0.
REQ-032 Backpressure: out_ready=0 for 5 cycles during OUT -> outputs and sel_id stable, out_valid held, no new ack; accept on cycle 6.
REQ-033 Timeout, TIMEOUT=16: only bot 1 requests -> frame_done with frame_timeout=1, missing=3'b101, 16 cycles after grant.
REQ-034 Repeat-request mask: bot 0 keeps req high after service while bot 2 requests late -> bot 0 not regranted; bot 2 granted next.
REQ-035 Reset mid-operation: rst asserted while in OUT -> out_valid=0 immediately (asynchronous); after release, served=0 and bot 0 is granted first.
